// File: rtl/eccdh3des_host_seq.sv
// Host-side session sequencer for the ECC-DH/3DES core.
// Runs: ECC phase 1 -> peer key exchange -> ECC phase 2 -> 3DES key load -> N data blocks.
// Core results have no backpressure, so they land in an output FIFO and input blocks
// are only accepted while a FIFO slot is reserved for their result (credit control).
// Optional build macro HOST_SEQ_TIMEOUT_EN adds a watchdog on the core wait states
// and the sticky timeout_err output.
module eccdh3des_host_seq #(
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             go,
    input  logic             cfg_encrypt,
    input  logic [CNT_W-1:0] cfg_blocks,
    output logic             busy,
    output logic             sess_done,
    output logic             pub_ready,
    input  logic             peer_ok,
    input  logic [63:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [63:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ecc1_start,
    output logic             ecc2_start,
    output logic             des_start,
    input  logic             ecc1_done,
    input  logic             ecc2_done,
    input  logic             des_done,
    output logic [63:0]      raw_data,
    output logic             data_valid_in,
    output logic             is_encrypt,
    input  logic [63:0]      encrypted_data,
    input  logic             data_valid_out
`ifdef HOST_SEQ_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        IDLE, E1_GO, E1_WAIT, XCHG, E2_GO, E2_WAIT, D_GO, D_WAIT, STREAM, FIN
    } state_t;

    typedef struct packed {
        logic             enc;
        logic [CNT_W-1:0] blocks;
    } cfg_t;

    state_t state, state_nxt;
    cfg_t   cfg;

    logic [2:0]       done_q;
    logic [2:0]       rise;
    logic [CNT_W-1:0] sent, recv;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    count;
    logic [AW-1:0]    wptr, rptr;
    logic [FIFO_DEPTH-1:0][63:0] mem;

    logic push, pop, accept, full, credit_ok, last_push, stream_end, go_acc;

    // Only a fresh rising edge of a done level can advance a wait state.
    assign rise       = {des_done, ecc2_done, ecc1_done} & ~done_q;
    assign go_acc     = (state == IDLE) && go;
    assign push       = data_valid_out && (state == STREAM);
    assign pop        = out_valid && out_ready;
    assign accept     = in_valid && in_ready;
    assign full       = (count == CW'(FIFO_DEPTH));
    assign credit_ok  = ({1'b0, count} + {1'b0, inflight}) < DEPTH_V;
    assign last_push  = push && (({1'b0, recv} + 1'b1) == {1'b0, cfg.blocks});
    assign stream_end = (recv == cfg.blocks) || last_push;
    assign out_valid  = (count != '0);
    assign out_data   = mem[rptr];
    assign is_encrypt = cfg.enc;

`ifdef HOST_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    logic          in_wait, tmo_hit;
    assign in_wait = (state == E1_WAIT) || (state == E2_WAIT) || (state == D_WAIT);
    assign tmo_hit = in_wait && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // Watchdog: counts cycles spent in the current wait state, restarts on every state change.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_nxt != state) tmo_cnt <= '0;
            else if (in_wait)       tmo_cnt <= tmo_cnt + 1'b1;
            if (go_acc)       timeout_err <= 1'b0;
            else if (tmo_hit) timeout_err <= 1'b1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and state-decoded control outputs.
    always_comb begin
        state_nxt  = state;
        busy       = (state != IDLE) && (state != FIN);
        sess_done  = (state == FIN);
        pub_ready  = (state == XCHG);
        ecc1_start = (state == E1_GO);
        ecc2_start = (state == E2_GO);
        des_start  = (state == D_GO);
        in_ready   = (state == STREAM) && (sent < cfg.blocks) && credit_ok;
        case (state)
            IDLE:    if (go)      state_nxt = E1_GO;
            E1_GO:                state_nxt = E1_WAIT;
            E1_WAIT: if (rise[0]) state_nxt = XCHG;
            XCHG:    if (peer_ok) state_nxt = E2_GO;
            E2_GO:                state_nxt = E2_WAIT;
            E2_WAIT: if (rise[1]) state_nxt = D_GO;
            D_GO:                 state_nxt = D_WAIT;
            D_WAIT:  if (rise[2]) state_nxt = (cfg.blocks == '0) ? FIN : STREAM;
            STREAM:  if (stream_end) state_nxt = FIN;
            FIN:                  state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
`ifdef HOST_SEQ_TIMEOUT_EN
        if (tmo_hit) state_nxt = FIN;
`endif
    end

    // Session config latch, block counters, credit bookkeeping and core input strobe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            done_q        <= '0;
            cfg           <= '0;
            sent          <= '0;
            recv          <= '0;
            inflight      <= '0;
            raw_data      <= '0;
            data_valid_in <= 1'b0;
        end else begin
            done_q        <= {des_done, ecc2_done, ecc1_done};
            data_valid_in <= accept;
            if (accept) raw_data <= in_data;
            if (go_acc) begin
                cfg      <= '{enc: cfg_encrypt, blocks: cfg_blocks};
                sent     <= '0;
                recv     <= '0;
                inflight <= '0;
            end else begin
                if (accept) sent <= sent + 1'b1;
                if (push)   recv <= recv + 1'b1;
                case ({accept, push})
                    2'b10:   inflight <= inflight + 1'b1;
                    2'b01:   inflight <= inflight - 1'b1;
                    default: inflight <= inflight;
                endcase
            end
        end
    end

    // Output FIFO; contents survive session end and remain poppable from IDLE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= encrypted_data;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A push into a full FIFO without a matching pop means the credit scheme is broken.
    fifo_no_overflow: assert property (@(posedge clk) disable iff (!n_rst) !(push && full && !pop));

endmodule

// File: tb/tb_eccdh3des_host_seq.sv
// Bench for eccdh3des_host_seq: core behavioural model plus directed and random sessions.
module tb_eccdh3des_host_seq;
    localparam int CNT_W = 16;

    logic             clk = 1'b0, n_rst = 1'b1, go = 1'b0, cfg_encrypt = 1'b0;
    logic [CNT_W-1:0] cfg_blocks = '0;
    logic             busy, sess_done, pub_ready, peer_ok = 1'b0;
    logic [63:0]      in_data = '0;
    logic             in_valid = 1'b0, in_ready;
    logic [63:0]      out_data;
    logic             out_valid, out_ready = 1'b0;
    logic             ecc1_start, ecc2_start, des_start;
    logic             ecc1_done, ecc2_done, des_done;
    logic [63:0]      raw_data, encrypted_data;
    logic             data_valid_in, is_encrypt, data_valid_out;
`ifdef HOST_SEQ_TIMEOUT_EN
    logic             timeout_err;
`endif

    always #5 clk = ~clk;

    eccdh3des_host_seq dut (
        .clk(clk), .n_rst(n_rst), .go(go), .cfg_encrypt(cfg_encrypt), .cfg_blocks(cfg_blocks),
        .busy(busy), .sess_done(sess_done), .pub_ready(pub_ready), .peer_ok(peer_ok),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ecc1_start(ecc1_start), .ecc2_start(ecc2_start), .des_start(des_start),
        .ecc1_done(ecc1_done), .ecc2_done(ecc2_done), .des_done(des_done),
        .raw_data(raw_data), .data_valid_in(data_valid_in), .is_encrypt(is_encrypt),
        .encrypted_data(encrypted_data), .data_valid_out(data_valid_out)
`ifdef HOST_SEQ_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    // Block transform performed by the modelled core.
    function automatic logic [63:0] fx(input logic [63:0] x, input logic e);
        if (e) return {x[31:0], x[63:32]} ^ 64'h0123456789ABCDEF;
        return ~x + 64'd7;
    endfunction

    // Core model: each engine raises its done level lat cycles after start, holds it until next start.
    int         lat[3] = '{5, 5, 5};
    int         cnt_m[3] = '{0, 0, 0};
    logic [2:0] run_m = '0, done_m = '0, st_m;
    logic       e2_man = 1'b0, e2_val = 1'b0;
    assign st_m = {des_start, ecc2_start, ecc1_start};
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (st_m[k]) begin
                done_m[k] <= 1'b0; run_m[k] <= 1'b1; cnt_m[k] <= lat[k];
            end else if (run_m[k]) begin
                if (cnt_m[k] <= 1) begin done_m[k] <= 1'b1; run_m[k] <= 1'b0; end
                else cnt_m[k] <= cnt_m[k] - 1;
            end
        end
    end
    assign ecc1_done = done_m[0];
    assign ecc2_done = e2_man ? e2_val : done_m[1];
    assign des_done  = done_m[2];

    // DES datapath model: fixed 4-stage latency.
    logic [3:0]  dvp = '0;
    logic [63:0] dp[4] = '{default: 64'd0};
    always @(posedge clk) begin
        dvp   <= {dvp[2:0], data_valid_in};
        dp[0] <= fx(raw_data, is_encrypt);
        for (int k = 1; k < 4; k++) dp[k] <= dp[k-1];
    end
    assign data_valid_out = dvp[3];
    assign encrypted_data = dp[3];

    int checks = 0, errors = 0;
    int cyc = 0;
    int n_e1, n_e2, n_d, n_sd, n_pub, n_acc, n_pop, t_e1, t_e2, t_d, t_sd, t_dvo, sd_run, sd_max;
    logic sd_busy, ir_seen, feed_en = 1'b0, sess_enc;
    int   or_mode = 0, sess_blocks;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One cycle: observe at negedge, drive inputs, then record the transfers of the coming edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (ecc1_start) begin n_e1++; t_e1 = cyc; end
        if (ecc2_start) begin n_e2++; t_e2 = cyc; end
        if (des_start)  begin n_d++;  t_d  = cyc; end
        if (pub_ready)  n_pub++;
        if (sess_done) begin
            n_sd++; t_sd = cyc; sd_busy = busy; sd_run++;
            if (sd_run > sd_max) sd_max = sd_run;
        end else sd_run = 0;
        if (data_valid_out) t_dvo = cyc;
        if (in_ready) ir_seen = 1'b1;
        in_valid = feed_en && ($urandom_range(0, 3) != 0);
        in_data  = {$urandom, $urandom};
        case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (in_valid && in_ready) begin exp_q.push_back(fx(in_data, sess_enc)); n_acc++; end
        if (out_valid && out_ready) begin
            n_pop++;
            chk("pop_avail", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("pop_data", out_data, exp_q.pop_front());
        end
    endtask

    task automatic go_sess(input int blocks, input logic enc);
        n_e1 = 0; n_e2 = 0; n_d = 0; n_sd = 0; n_pub = 0; n_acc = 0; n_pop = 0;
        sd_run = 0; sd_max = 0; ir_seen = 1'b0; sess_enc = enc; sess_blocks = blocks;
        cfg_blocks = CNT_W'(blocks); cfg_encrypt = enc; go = 1'b1;
        step();
        go = 1'b0; cfg_blocks = CNT_W'($urandom); cfg_encrypt = ~enc;
    endtask

    task automatic wait_sd(input string tag, input int maxc);
        for (int i = 0; i < maxc && n_sd == 0; i++) step();
        chk({tag, "_sess_done"}, 64'(n_sd), 64'd1);
    endtask

    task automatic drain_check(input string tag);
        chk({tag, "_sd_width"}, 64'(sd_max), 64'd1);
        chk({tag, "_busy_at_sd"}, 64'(sd_busy), 64'd0);
        feed_en = 1'b0; or_mode = 1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        step();
        chk({tag, "_pops"}, 64'(n_pop), 64'(sess_blocks));
        chk({tag, "_accepts"}, 64'(n_acc), 64'(sess_blocks));
        chk({tag, "_starts"}, {32'(n_e1), 16'(n_e2), 16'(n_d)}, {32'd1, 16'd1, 16'd1});
        chk({tag, "_order"}, 64'((t_e1 < t_e2) && (t_e2 < t_d)), 64'd1);
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic bad;
        int   t0;
        // Reset state
        #2 n_rst = 1'b0;
        #20;
        chk("rst_ctrl", {54'd0, busy, sess_done, pub_ready, in_ready, out_valid, ecc1_start,
                         ecc2_start, des_start, data_valid_in, is_encrypt}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_raw_data", raw_data, 64'd0);
        step(); step();
        n_rst = 1'b1;
        step();

        // T1: 3-block session, pub_ready held until peer_ok
        lat = '{5, 7, 3}; or_mode = 1; feed_en = 1'b1; peer_ok = 1'b0;
        go_sess(3, 1'b1);
        for (int i = 0; i < 100 && !pub_ready; i++) step();
        chk("t1_pub_ready", {63'd0, pub_ready}, 64'd1);
        bad = 1'b0;
        repeat (10) begin step(); if (!pub_ready) bad = 1'b1; end
        chk("t1_pub_hold", {63'd0, bad}, 64'd0);
        chk("t1_no_e2_early", 64'(n_e2), 64'd0);
        peer_ok = 1'b1;
        step();
        chk("t1_e2_start", {62'd0, ecc2_start, pub_ready}, 64'd2);
        peer_ok = 1'b0;
        wait_sd("t1", 500);
        chk("t1_sd_after_push", 64'(t_sd), 64'(t_dvo + 1));
        drain_check("t1");

        // T2: 20 blocks with stalled output: credits cap accepts at FIFO depth
        lat = '{3, 3, 3}; peer_ok = 1'b1; or_mode = 0; feed_en = 1'b1;
        go_sess(20, 1'b0);
        repeat (80) step();
        chk("t2_accepts_capped", 64'(n_acc), 64'd8);
        chk("t2_in_ready_low", {62'd0, in_ready, out_valid}, 64'd1);
        chk("t2_xchg_entry_peer_ok", 64'(n_pub), 64'd1);
        or_mode = 2;
        wait_sd("t2", 3000);
        drain_check("t2");

        // T3: stale ecc2_done level must not skip E2_WAIT
        lat = '{4, 4, 4}; or_mode = 1; feed_en = 1'b1; e2_man = 1'b1; e2_val = 1'b1;
        go_sess(1, 1'b1);
        for (int i = 0; i < 100 && n_e2 == 0; i++) step();
        chk("t3_e2_started", 64'(n_e2), 64'd1);
        repeat (3) step();
        e2_val = 1'b0;
        repeat (50) step();
        chk("t3_no_skip", 64'(n_d), 64'd0);
        chk("t3_ecc1_held", {63'd0, ecc1_done}, 64'd1);
        e2_val = 1'b1; t0 = cyc;
        for (int i = 0; i < 10 && n_d == 0; i++) step();
        chk("t3_des_after_rise", 64'(t_d), 64'(t0 + 1));
        wait_sd("t3", 500);
        drain_check("t3");
        e2_man = 1'b0;

        // T4: go during STREAM is ignored
        or_mode = 0; feed_en = 1'b1;
        go_sess(5, 1'b0);
        for (int i = 0; i < 200 && n_acc < 3; i++) step();
        go = 1'b1; cfg_encrypt = 1'b1; cfg_blocks = 16'd2;
        step();
        go = 1'b0;
        repeat (3) step();
        chk("t4_cfg_kept", {62'd0, is_encrypt, busy}, 64'd1);
        chk("t4_no_restart", 64'(n_e1), 64'd1);
        or_mode = 1;
        wait_sd("t4", 500);
        drain_check("t4");

        // T5: zero blocks goes straight from des_done to FIN
        lat = '{2, 2, 6}; feed_en = 1'b1;
        go_sess(0, 1'b1);
        wait_sd("t5", 500);
        chk("t5_sd_time", 64'(t_sd), 64'(t_d + lat[2] + 2));
        chk("t5_in_ready_never", {63'd0, ir_seen}, 64'd0);
        drain_check("t5");

        // T6: asynchronous reset mid-stream
        lat = '{3, 3, 3}; or_mode = 0; feed_en = 1'b1;
        go_sess(6, 1'b1);
        for (int i = 0; i < 200 && n_acc < 2; i++) step();
        step();
        n_rst = 1'b0;
        #1;
        chk("t6_rst_ctrl", {54'd0, busy, sess_done, pub_ready, in_ready, out_valid, ecc1_start,
                            ecc2_start, des_start, data_valid_in, is_encrypt}, 64'd0);
        chk("t6_rst_data", out_data | raw_data, 64'd0);
        feed_en = 1'b0;
        step(); step();
        n_rst = 1'b1;
        exp_q.delete();
        repeat (10) step();
        chk("t6_fifo_empty", {62'd0, out_valid, busy}, 64'd0);

        // T7: random sessions
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) lat[k] = $urandom_range(1, 8);
            or_mode = 2; feed_en = 1'b1; peer_ok = 1'b1;
            go_sess($urandom_range(1, 12), 1'($urandom_range(0, 1)));
            wait_sd($sformatf("t7_%0d", r), 2000);
            drain_check($sformatf("t7_%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
